// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the pipelined MIPS core.
//   - Opcode / funct field values used by decode.
//   - Fetch-stage state encoding (2 bits).
//   - Word size in bytes used for PC stepping.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] OPR_ADD = 6'h20;
  localparam logic [5:0] OPR_SUB = 6'h22;

  // Bytes per instruction word
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: combinational PC-relative branch target.
//   pc4    in  32  PC+4 of the branch instruction
//   imm16  in  16  signed word offset
//   target out 32  pc4 + sign_extend(imm16) << 2, modulo 2^32
// The result is always word-aligned when pc4 is, since the offset is a
// multiple of four.
module branch_target_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [15:0] imm16,
  output logic [31:0] target
);

  logic [31:0] offset_s;

  // Sign-extend the word offset and convert it to a byte offset
  always_comb begin
    offset_s = {{14{imm16[15]}}, imm16, 2'b00};
    target   = pc4 + offset_s;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with IF/ID register.
//   clk, reset          clock, asynchronous active-high reset
//   start               leaves IDLE and begins fetching
//   stall               hold pc and IF/ID
//   branch_taken        PC-relative redirect (branch_pc4, branch_imm)
//   jump_reg            absolute redirect to jump_target
//   imem_addr / imem_data  instruction memory address / combinational data
//   if_instr, if_pc4, if_valid  IF/ID register contents
//   fetch_count         number of valid instructions latched
//   fault               sticky misaligned-fetch fault
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [15:0] branch_imm,
  input  logic        jump_reg,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic        fault
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  if_instr_r;
  logic [31:0]  if_pc4_r;
  logic         if_valid_r;
  logic [31:0]  fetch_count_r;
  logic         fault_r;
  logic [31:0]  branch_target_s;
  logic [31:0]  pc_next_seq_s;

  branch_target_calc u_btc (
    .pc4    (branch_pc4),
    .imm16  (branch_imm),
    .target (branch_target_s)
  );

  // Sequential PC increment, wraps modulo 2^32
  always_comb begin
    pc_next_seq_s = pc_r + WORD_BYTES;
  end

  // Fetch FSM: PC, IF/ID register, counter and fault flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= FETCH_IDLE;
      pc_r          <= RESET_PC;
      if_instr_r    <= 32'd0;
      if_pc4_r      <= 32'd0;
      if_valid_r    <= 1'b0;
      fetch_count_r <= 32'd0;
      fault_r       <= 1'b0;
    end else begin
      case (state_r)
        FETCH_IDLE: begin
          if (start) begin
            state_r <= FETCH_RUN;
          end
        end
        FETCH_RUN: begin
          // Redirects beat stall: the resolving instruction is downstream
          if (jump_reg) begin
            pc_r       <= jump_target;
            if_instr_r <= 32'd0;
            if_valid_r <= 1'b0;
            if (jump_target[1:0] != 2'b00) begin
              state_r <= FETCH_FAULT;
              fault_r <= 1'b1;
            end
          end else if (branch_taken) begin
            pc_r       <= branch_target_s;
            if_instr_r <= 32'd0;
            if_valid_r <= 1'b0;
          end else if (!stall) begin
            if_instr_r    <= imem_data;
            if_pc4_r      <= pc_next_seq_s;
            if_valid_r    <= 1'b1;
            pc_r          <= pc_next_seq_s;
            fetch_count_r <= fetch_count_r + 32'd1;
          end
        end
        FETCH_FAULT: begin
          if_valid_r <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely in FAULT
          state_r    <= FETCH_FAULT;
          fault_r    <= 1'b1;
          if_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc_r;
  assign if_instr    = if_instr_r;
  assign if_pc4      = if_pc4_r;
  assign if_valid    = if_valid_r;
  assign fetch_count = fetch_count_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit with a small
// behavioural instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [15:0] branch_imm;
  logic        jump_reg;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic        fault;

  int checks;
  int errors;

  logic [31:0] mem [0:7];

  fetch_unit #(.RESET_PC(32'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc4   (branch_pc4),
    .branch_imm   (branch_imm),
    .jump_reg     (jump_reg),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_instr     (if_instr),
    .if_pc4       (if_pc4),
    .if_valid     (if_valid),
    .fetch_count  (fetch_count),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: 8 programmed words at 0..28, elsewhere 0xC0000000 | addr
  always_comb begin
    if (imem_addr < 32'd32) imem_data = mem[imem_addr[4:2]];
    else                    imem_data = 32'hC000_0000 | imem_addr;
  end

  typedef struct {
    logic        start;
    logic        stall;
    logic        br;
    logic [31:0] bpc4;
    logic [15:0] bimm;
    logic        jr;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_count;
    logic        e_fault;
  } vec_t;

  vec_t vecs [0:19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid, input logic [31:0] cnt,
                         input logic flt);
    chk({tag, " imem_addr"},   imem_addr,   pc);
    chk({tag, " if_instr"},    if_instr,    instr);
    chk({tag, " if_pc4"},      if_pc4,      pc4);
    chk({tag, " if_valid"},    {31'd0, if_valid}, {31'd0, valid});
    chk({tag, " fetch_count"}, fetch_count, cnt);
    chk({tag, " fault"},       {31'd0, fault},    {31'd0, flt});
  endtask

  task automatic drive(input logic s, input logic st, input logic b, input logic [31:0] bp,
                       input logic [15:0] bi, input logic j, input logic [31:0] jt);
    start = s; stall = st; branch_taken = b; branch_pc4 = bp;
    branch_imm = bi; jump_reg = j; jump_target = jt;
  endtask

  function automatic vec_t mk(input logic s, input logic st, input logic b,
                              input logic [31:0] bp, input logic [15:0] bi, input logic j,
                              input logic [31:0] jt, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] p4, input logic v,
                              input logic [31:0] c, input logic f);
    vec_t r;
    r.start = s; r.stall = st; r.br = b; r.bpc4 = bp; r.bimm = bi; r.jr = j; r.jt = jt;
    r.e_pc = pc; r.e_instr = ins; r.e_pc4 = p4; r.e_valid = v; r.e_count = c; r.e_fault = f;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020; mem[3] = 32'h1109_FFFD;
    mem[4] = 32'h0000_0000; mem[5] = 32'hAC0A_0000;
    mem[6] = 32'h8C0B_0000; mem[7] = 32'h1000_FFFF;

    //            start stall br bpc4       bimm      jr jt            | pc            instr          pc4       v  cnt    flt
    vecs[0]  = mk(1'b0, 1'b1, 1'b1, 32'd20, 16'hFFFD, 1'b1, 32'h40,       32'd0,  32'd0, 32'd0,  1'b0, 32'd0, 1'b0); // IDLE ignores all
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd0,  32'd0, 32'd0,  1'b0, 32'd0, 1'b0); // start: state only
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd4,  mem[0], 32'd4, 1'b1, 32'd1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd8,  mem[1], 32'd8, 1'b1, 32'd2, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd12, mem[2], 32'd12, 1'b1, 32'd3, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd16, mem[3], 32'd16, 1'b1, 32'd4, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd20, 32'd0, 32'd20, 1'b1, 32'd5, 1'b0); // nop word latched
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 32'd20, 16'hFFFD, 1'b0, 32'h0,        32'd8,  32'd0, 32'd20, 1'b0, 32'd5, 1'b0); // branch back to 8
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd12, mem[2], 32'd12, 1'b1, 32'd6, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd12, mem[2], 32'd12, 1'b1, 32'd6, 1'b0); // stall x3
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd12, mem[2], 32'd12, 1'b1, 32'd6, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd12, mem[2], 32'd12, 1'b1, 32'd6, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 32'd4,  16'h0005, 1'b0, 32'h0,        32'd24, 32'd0, 32'd12, 1'b0, 32'd6, 1'b0); // branch beats stall
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd28, mem[6], 32'd28, 1'b1, 32'd7, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 32'd4,  16'h0005, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0, 32'd28, 1'b0, 32'd7, 1'b0); // jr beats branch
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd0,  32'hFFFF_FFFC, 32'd0, 1'b1, 32'd8, 1'b0); // pc wraps
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd4,  mem[0], 32'd4, 1'b1, 32'd9, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b1, 32'h0000_0006, 32'd6, 32'd0, 32'd4, 1'b0, 32'd9, 1'b1); // misaligned jr
    vecs[18] = mk(1'b1, 1'b0, 1'b1, 32'd4,  16'h0005, 1'b1, 32'h40,       32'd6,  32'd0, 32'd4,  1'b0, 32'd9, 1'b1); // FAULT frozen
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'd0,  16'h0,    1'b0, 32'h0,        32'd6,  32'd0, 32'd4,  1'b0, 32'd9, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 32'd0);
    reset = 1'b1;
    #12;
    chk_all("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].br, vecs[i].bpc4, vecs[i].bimm,
            vecs[i].jr, vecs[i].jt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
              vecs[i].e_valid, vecs[i].e_count, vecs[i].e_fault);
    end

    // Asynchronous reset out of FAULT, mid-cycle
    drive(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_all("rst_fault", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    #2;
    reset = 1'b0;

    // Restart and fetch three words
    drive(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("refetch", 32'd12, mem[2], 32'd12, 1'b1, 32'd3, 1'b0);

    // Asynchronous reset during RUN, checked before the next edge
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst_run", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    #1;
    reset = 1'b0;
    // Back in IDLE: no fetch without start
    @(posedge clk);
    #1;
    chk_all("idle_after_rst", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
